mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Round-robin arbiter that shares the single external memory bus between up to N requesters: the ring-buffer memory writers and readers. Each requester raises a request and holds it while its transfer runs. The arbiter issues a one-hot grant, keeps it until the owner signals completion, inserts one bus-turnaround cycle, then moves the priority pointer past the last owner. It sits between the writer/reader clients and the shared memory port, replacing fixed-size arbiters with one parameterised block.

## Interface
Parameters:
- N, 8, number of requesters (2..16)
- W, $clog2(N), owner index width (derived; do not override)
- HOLD_MAX, 64, maximum grant length in cycles (used only when the timeout feature is compiled in; 2..65535)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- req  in  N  per-client request, level; held until the client's done or its own withdrawal
- done  in  N  per-client completion, single-cycle pulse; ignored unless that client currently owns the grant
- grant  out  N  one-hot grant, registered; all-zero when no owner
- owner  out  W  index of the current owner; valid only while busy=1
- busy  out  1  1 while any grant is active
- timeout  out  N  one-cycle pulse on the client whose grant was forcibly revoked; constant 0 without the macro

## Operation
- States: IDLE, GRANT, GAP.
- Reset values (while rst=0): state=IDLE, grant=0, owner=0, busy=0, timeout=0, ptr=0, hold counter=0.
- Arbitration happens only in IDLE. The winner is the first set bit of req found by scanning from index ptr upward, wrapping modulo N.
- IDLE with req≠0: register the winner's grant, owner and busy=1, then go to GRANT. IDLE with req=0: stay.
- GRANT: the grant is held steady. Exit to GAP when any of these is sampled:
  - done[owner]=1, or
  - req[owner]=0 (withdrawal), or
  - a timeout (macro only).
- On GRANT exit: grant=0, busy=0, ptr=(owner+1) mod N. Wrap is explicit, so owner=N-1 gives ptr=0.
- GAP: one idle bus cycle, then IDLE unconditionally.
- Requests from non-owners during GRANT/GAP are not lost; they are evaluated at the next IDLE.
- done on a non-owner is ignored. done and req withdrawal in the same cycle count as one release.
- At most one grant bit is ever set. grant and owner always agree.
- Reset mid-grant clears grant asynchronously. No release cycle or timeout pulse is produced.

## Timing
- Grant latency: req sampled high at edge k in IDLE gives grant high after edge k.
- Release: done sampled at edge m gives grant low after edge m. GAP covers the cycle m..m+1, IDLE covers m+1..m+2, and the earliest next grant is after edge m+2.
- Minimum spacing between two grants: 2 cycles of grant=0.
- Back-to-back ownership by the same client is allowed if it is the only requester. It still passes through GAP and IDLE.
- Worst-case wait, with the timeout enabled: (N-1)·(HOLD_MAX+2) cycles.

## Configuration
- ARB_HOLD_TIMEOUT_EN defined:
  - A 16-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches HOLD_MAX-1 and no done/withdrawal is sampled at that edge, the arbiter revokes the grant and pulses timeout[owner] for one cycle (concurrent with grant dropping), then enters GAP with normal ptr advance.
  - done on the same edge takes precedence: release happens with no timeout pulse.
- ARB_HOLD_TIMEOUT_EN undefined:
  - No counter is synthesised, timeout is tied to 0, and HOLD_MAX is ignored.
  - A grant is held indefinitely until done or withdrawal.

## Test plan
- Reset with req=8'hFF asserted, then release rst: grant=0 during reset; grant=8'h01 and owner=0 one edge after release.
- req=8'h81 held, done pulsed by each owner in turn: grants alternate 8'h01 → 8'h80 → 8'h01, each separated by exactly 2 cycles of grant=0.
- Owner 3 holds, done pulsed on clients 5 and 0 (non-owners): grant stays 8'h08. done[3] then gives grant=0 on the next edge and ptr=4.
- req=8'hFF with an immediate done each grant: grant order is 0,1,…,7,0, confirming modulo-N wrap from owner 7 to ptr 0.
- Macro on, HOLD_MAX=4, client 2 never asserts done: grant drops after 4 GRANT cycles, timeout=8'h04 for one cycle, and next requester 3 is granted 2 cycles later.
- rst asserted mid-grant (owner 6): grant, busy and timeout go to 0 immediately. After release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Request/grant bundle between ring-buffer clients and the shared memory bus arbiter.
interface mem_bus_arbiter_if #(
   parameter int N = 8,
   parameter int W = $clog2(N)
);
   logic [N-1:0] req;
   logic [N-1:0] done;
   logic [N-1:0] grant;
   logic [W-1:0] owner;
   logic         busy;
   logic [N-1:0] timeout;

   modport master (output req, done, input grant, owner, busy, timeout);
   modport slave  (input req, done, output grant, owner, busy, timeout);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared memory bus: one-hot grant, one turnaround cycle per release.
// Optional grant-length watchdog compiled in with `define ARB_HOLD_TIMEOUT_EN.
module mem_bus_arbiter #(
   parameter int N        = 8,
   parameter int W        = $clog2(N),
   parameter int HOLD_MAX = 64
) (
   input  logic            clk,
   input  logic            rst,
   mem_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   if (N < 2 || N > 16 || HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_bad_param
      $error("mem_bus_arbiter: parameter out of range");
   end

   state_t       state_q, state_d;
   logic [N-1:0] grant_q, grant_d;
   logic [W-1:0] owner_q, owner_d;
   logic         busy_q, busy_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic         win_found;
   logic [W-1:0] win_idx;
   int unsigned  scan_idx;
   logic         release_now;
`ifdef ARB_HOLD_TIMEOUT_EN
   logic [15:0]  cnt_q, cnt_d;
   logic [N-1:0] timeout_q, timeout_d;
   logic         expire;
`endif

   // First requester at or after ptr, wrapping modulo N.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int unsigned i = 0; i < N; i++) begin
         scan_idx = (32'(ptr_q) + i) % N;
         if (!win_found && bus.req[W'(scan_idx)]) begin
            win_found = 1'b1;
            win_idx   = W'(scan_idx);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      busy_d      = busy_q;
      ptr_d       = ptr_q;
      release_now = bus.done[owner_q] || !bus.req[owner_q];
`ifdef ARB_HOLD_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_d   = '0;
      expire      = (cnt_q == 16'(HOLD_MAX - 1));
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               owner_d          = win_idx;
               busy_d           = 1'b1;
               state_d          = GRANT;
`ifdef ARB_HOLD_TIMEOUT_EN
               cnt_d            = '0;
`endif
            end
         end
         GRANT: begin
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_d = cnt_q + 16'd1;
            if (release_now || expire) begin
               timeout_d[owner_q] = !release_now;
`else
            if (release_now) begin
`endif
               grant_d = '0;
               busy_d  = 1'b0;
               ptr_d   = (owner_q == W'(N - 1)) ? '0 : owner_q + 1'b1;
               state_d = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef ARB_HOLD_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         timeout_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = '0;
`endif

   assign bus.grant = grant_q;
   assign bus.owner = owner_q;
   assign bus.busy  = busy_q;
endmodule
